// File: rtl/fpu_add_driver.sv
// fpu_add_driver: queues operand pairs and sequences them through the FPU adder handshake with watchdog recovery
module fpu_add_driver #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                job_a,
    input  logic [31:0]                job_b,
    input  logic                       job_valid,
    output logic                       job_ready,
    output logic [$clog2(DEPTH):0]     job_count,
    output logic [31:0]                res_z,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic                       fpu_start,
    input  logic                       fpu_idle,
    output logic [31:0]                fpu_a,
    output logic                       fpu_a_stb,
    input  logic                       fpu_a_ack,
    output logic [31:0]                fpu_b,
    output logic                       fpu_b_stb,
    input  logic                       fpu_b_ack,
    input  logic [31:0]                fpu_z,
    input  logic                       fpu_z_stb,
    output logic                       fpu_ack_output,
    input  logic                       fpu_valid,
    output logic                       fpu_rst,
    output logic                       err,
    input  logic                       err_clr,
    output logic [7:0]                 err_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, START, SEND_A, SEND_B, WAIT_Z, WAIT_VAL, PUSH, RECOVER} state_t;

    state_t        state;
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [WW-1:0] wd;
    logic          push;
    logic          pop;
    logic          busy;
    logic          adv;
    logic          tmo;

    assign job_ready = job_count != FULL;
    assign push      = job_valid && job_ready;
    assign pop       = state == IDLE && job_count != '0 && fpu_idle;
    assign busy      = state inside {START, SEND_A, SEND_B, WAIT_Z, WAIT_VAL};

    // exit condition of each adder wait state
    always_comb begin
        adv = state == START    ? !fpu_idle :
              state == SEND_A   ? fpu_a_ack :
              state == SEND_B   ? fpu_b_ack :
              state == WAIT_Z   ? fpu_z_stb :
              state == WAIT_VAL ? fpu_valid : 1'b0;
    end

    assign tmo = busy && !adv && wd == WW'(TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {job_a, job_b};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            job_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            job_count <= job_count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            wd             <= '0;
            fpu_start      <= 1'b0;
            fpu_a          <= '0;
            fpu_a_stb      <= 1'b0;
            fpu_b          <= '0;
            fpu_b_stb      <= 1'b0;
            fpu_ack_output <= 1'b0;
            res_z          <= '0;
            res_valid      <= 1'b0;
            fpu_rst        <= 1'b0;
            err            <= 1'b0;
            err_count      <= '0;
        end else begin
            fpu_rst <= 1'b0;
            wd      <= busy && !adv ? wd + WW'(1) : '0;
            if (err_clr) err <= 1'b0;
            // a timeout overrides both the state step and a same-cycle err_clr
            if (tmo) begin
                state          <= RECOVER;
                wd             <= '0;
                fpu_start      <= 1'b0;
                fpu_a_stb      <= 1'b0;
                fpu_b_stb      <= 1'b0;
                fpu_ack_output <= 1'b0;
                fpu_rst        <= 1'b1;
                err            <= 1'b1;
                err_count      <= err_count + 8'(err_count != 8'hFF);
            end else begin
                case (state)
                    IDLE: if (pop) begin
                        fpu_a     <= mem[rd_ptr][63:32];
                        fpu_b     <= mem[rd_ptr][31:0];
                        fpu_start <= 1'b1;
                        state     <= START;
                    end
                    START: if (adv) begin
                        fpu_start <= 1'b0;
                        fpu_a_stb <= 1'b1;
                        state     <= SEND_A;
                    end
                    SEND_A: if (adv) begin
                        fpu_a_stb <= 1'b0;
                        fpu_b_stb <= 1'b1;
                        state     <= SEND_B;
                    end
                    SEND_B: if (adv) begin
                        fpu_b_stb      <= 1'b0;
                        fpu_ack_output <= 1'b1;
                        state          <= WAIT_Z;
                    end
                    WAIT_Z: if (adv) begin
                        res_z <= fpu_z;
                        state <= WAIT_VAL;
                    end
                    WAIT_VAL: if (adv) begin
                        fpu_ack_output <= 1'b0;
                        res_valid      <= 1'b1;
                        state          <= PUSH;
                    end
                    PUSH: if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fpu_add_driver.sv
// tb_fpu_add_driver: behavioural adder stub plus in-order job scoreboard around fpu_add_driver
module tb_fpu_add_driver;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] job_a, job_b;
    logic        job_valid;
    logic        job_ready;
    logic [2:0]  job_count;
    logic [31:0] res_z;
    logic        res_valid;
    logic        res_ready;
    logic        fpu_start;
    logic        fpu_idle;
    logic [31:0] fpu_a;
    logic        fpu_a_stb;
    logic        fpu_a_ack;
    logic [31:0] fpu_b;
    logic        fpu_b_stb;
    logic        fpu_b_ack;
    logic [31:0] fpu_z;
    logic        fpu_z_stb;
    logic        fpu_ack_output;
    logic        fpu_valid;
    logic        fpu_rst;
    logic        err;
    logic        err_clr;
    logic [7:0]  err_count;

    fpu_add_driver #(.DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .job_a(job_a), .job_b(job_b), .job_valid(job_valid),
        .job_ready(job_ready), .job_count(job_count), .res_z(res_z), .res_valid(res_valid),
        .res_ready(res_ready), .fpu_start(fpu_start), .fpu_idle(fpu_idle), .fpu_a(fpu_a),
        .fpu_a_stb(fpu_a_stb), .fpu_a_ack(fpu_a_ack), .fpu_b(fpu_b), .fpu_b_stb(fpu_b_stb),
        .fpu_b_ack(fpu_b_ack), .fpu_z(fpu_z), .fpu_z_stb(fpu_z_stb),
        .fpu_ack_output(fpu_ack_output), .fpu_valid(fpu_valid), .fpu_rst(fpu_rst),
        .err(err), .err_clr(err_clr), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] a; logic [31:0] b;} job_t;
    typedef struct {logic [31:0] a; logic [31:0] b; logic [31:0] z;} vec_t;

    job_t        acc_q[$];
    vec_t        vt[5];
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_res = 0;
    logic [31:0] last_z;
    logic        stub_idle, hold_idle, hang_a, hang_z, stub_rand;
    logic        rr_rand = 1'b0;
    logic        rr_hold = 1'b1;
    int          sp, dly;
    logic [31:0] ga, gb;

    assign fpu_idle = stub_idle && !hold_idle;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic real s2r(input logic [31:0] x);
        if (x[30:0] == 31'd0) return 0.0;
        return $bitstoreal({x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] sp_add(input logic [31:0] a, input logic [31:0] b);
        return r2s(s2r(a) + s2r(b));
    endfunction

    function automatic logic [31:0] rnd_sp();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
    endfunction

    function automatic int rd();
        return stub_rand ? int'($urandom_range(0, 3)) : 0;
    endfunction

    // adder stub: acts on negedges, so every handshake it raises completes on the next posedge
    initial begin
        sp = 0; dly = 0; stub_idle = 1'b1;
        fpu_a_ack = 1'b0; fpu_b_ack = 1'b0; fpu_z_stb = 1'b0; fpu_valid = 1'b0; fpu_z = '0;
        forever begin
            @(negedge clk);
            if (rst || fpu_rst) begin
                sp = 0; dly = 0; stub_idle = 1'b1;
                fpu_a_ack = 1'b0; fpu_b_ack = 1'b0; fpu_z_stb = 1'b0; fpu_valid = 1'b0;
            end else if (dly > 0) dly--;
            else case (sp)
                0: if (fpu_start && fpu_idle) begin stub_idle = 1'b0; dly = rd(); sp = 1; end
                1: if (!hang_a) begin
                    fpu_a_ack = 1'b1;
                    if (fpu_a_stb) begin ga = fpu_a; sp = 2; end
                end
                2: begin
                    fpu_a_ack = 1'b0;
                    chk("fpu_a", ga, acc_q.size() > 0 ? acc_q[0].a : ~ga);
                    dly = rd(); sp = 3;
                end
                3: begin
                    fpu_b_ack = 1'b1;
                    if (fpu_b_stb) begin gb = fpu_b; sp = 4; end
                end
                4: begin
                    fpu_b_ack = 1'b0;
                    chk("fpu_b", gb, acc_q.size() > 0 ? acc_q[0].b : ~gb);
                    dly = rd(); sp = 5;
                end
                5: if (!hang_z && fpu_ack_output) begin fpu_z = sp_add(ga, gb); fpu_z_stb = 1'b1; sp = 6; end
                6: begin fpu_z_stb = 1'b0; dly = rd(); sp = 7; end
                default: if (!fpu_valid) fpu_valid = 1'b1;
                    else if (!fpu_ack_output) begin fpu_valid = 1'b0; stub_idle = 1'b1; sp = 0; end
            endcase
        end
    end

    // scoreboard: results must come back in acceptance order; a recovered job is dropped
    initial forever begin
        @(negedge clk);
        if (!rst && fpu_rst && acc_q.size() > 0) void'(acc_q.pop_front());
        if (!rst && res_valid && res_ready) begin
            chk("res_z", res_z, acc_q.size() > 0 ? sp_add(acc_q[0].a, acc_q[0].b) : ~res_z);
            if (acc_q.size() > 0) void'(acc_q.pop_front());
            last_z = res_z;
            n_res++;
        end
    end

    initial forever begin
        @(posedge clk);
        #1 res_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_hold;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1);
    end

    task automatic push_try(input logic [31:0] a, input logic [31:0] b, output bit ok);
        job_a = a; job_b = b; job_valid = 1'b1;
        ok = job_ready;
        if (ok) acc_q.push_back('{a: a, b: b});
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic push_job(input logic [31:0] a, input logic [31:0] b);
        int t = 0;
        job_a = a; job_b = b; job_valid = 1'b1;
        while (!job_ready && t < 200) begin @(negedge clk); t++; end
        chk("push_ready", 32'(job_ready), 32'd1);
        if (job_ready) acc_q.push_back('{a: a, b: b});
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic wait_res(input int target, input string name);
        int t = 0;
        while (n_res < target && t < 2000) begin @(negedge clk); t++; end
        chk(name, 32'(n_res), 32'(target));
    endtask

    task automatic run_to(input bit coincide, input int exp_cnt);
        int n = 0;
        int t = 0;
        bit ok;
        hang_a = 1'b1;
        push_try(rnd_sp(), rnd_sp(), ok);
        while (!fpu_a_stb && t < 20) begin @(negedge clk); t++; end
        while (fpu_a_stb && n < 40) begin
            n++;
            if (coincide && n == 16) err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
        end
        chk("to_cycles", 32'(n), 32'd16);
        chk("to_rst_high", 32'(fpu_rst), 32'd1);
        chk("to_strobes_low", {29'd0, fpu_start, fpu_b_stb, fpu_ack_output}, 32'd0);
        chk("to_err", 32'(err), 32'd1);
        chk("to_err_count", 32'(err_count), 32'(exp_cnt));
        @(negedge clk);
        chk("to_rst_one_cycle", 32'(fpu_rst), 32'd0);
        hang_a = 1'b0;
    endtask

    initial begin
        bit          ok;
        int          base, bad, t, acc;
        logic [31:0] exp_z, j1a;
        vt[0] = '{a: 32'h3F800000, b: 32'h40000000, z: 32'h40400000};
        vt[1] = '{a: 32'h40000000, b: 32'h40000000, z: 32'h40800000};
        vt[2] = '{a: 32'h3F800000, b: 32'hBF800000, z: 32'h00000000};
        vt[3] = '{a: 32'h40400000, b: 32'h3F000000, z: 32'h40600000};
        vt[4] = '{a: 32'hC0A00000, b: 32'h40400000, z: 32'hC0000000};
        rst = 1'b1; job_valid = 1'b0; job_a = '0; job_b = '0; res_ready = 1'b1; err_clr = 1'b0;
        hold_idle = 1'b0; hang_a = 1'b0; hang_z = 1'b0; stub_rand = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_job_ready", 32'(job_ready), 32'd1);
        chk("rst_job_count", 32'(job_count), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_fpu_start", 32'(fpu_start), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_res_z", res_z, 32'd0);
        chk("rst_fpu_a", fpu_a, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            base = n_res;
            push_try(vt[i].a, vt[i].b, ok);
            chk("vec_push", 32'(ok), 32'd1);
            if (i == 0) begin
                chk("lat_count_n", 32'(job_count), 32'd1);
                chk("lat_start_n", 32'(fpu_start), 32'd0);
                @(negedge clk);
                chk("lat_start_n1", 32'(fpu_start), 32'd1);
                chk("lat_count_n1", 32'(job_count), 32'd0);
            end
            wait_res(base + 1, "vec_done");
            chk("vec_z", last_z, vt[i].z);
        end

        base = n_res;
        hold_idle = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_try(rnd_sp(), rnd_sp(), ok);
            chk("full_push_ok", 32'(ok), 32'(i < 4));
            if (i == 3) chk("full_ready", 32'(job_ready), 32'd0);
        end
        chk("full_count", 32'(job_count), 32'd4);
        hold_idle = 1'b0;
        wait_res(base + 4, "full_drain");

        base = n_res;
        rr_hold = 1'b0;
        push_try(rnd_sp(), rnd_sp(), ok);
        push_try(rnd_sp(), rnd_sp(), ok);
        t = 0;
        while (!res_valid && t < 100) begin @(negedge clk); t++; end
        chk("bp_valid", 32'(res_valid), 32'd1);
        chk("bp_count", 32'(job_count), 32'd1);
        exp_z = sp_add(acc_q[0].a, acc_q[0].b);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_z !== exp_z || fpu_start !== 1'b0 || job_count !== 3'd1) bad++;
        end
        chk("bp_stable", 32'(bad), 32'd0);
        rr_hold = 1'b1;
        t = 0;
        while (!fpu_start && t < 8) begin @(negedge clk); t++; end
        chk("bp_next_start", 32'(fpu_start), 32'd1);
        wait_res(base + 2, "bp_drain");

        run_to(1'b0, 1);
        base = n_res;
        push_job(vt[0].a, vt[0].b);
        wait_res(base + 1, "post_to_done");
        chk("post_to_z", last_z, vt[0].z);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_err", 32'(err), 32'd0);
        chk("clr_err_count", 32'(err_count), 32'd1);
        run_to(1'b1, 2);

        base = n_res;
        hold_idle = 1'b1;
        push_try(rnd_sp(), rnd_sp(), ok);
        j1a = job_a;
        push_try(rnd_sp(), rnd_sp(), ok);
        chk("pp_count_before", 32'(job_count), 32'd2);
        hold_idle = 1'b0;
        push_try(rnd_sp(), rnd_sp(), ok);
        chk("pp_count_after", 32'(job_count), 32'd2);
        t = 0;
        while (!fpu_a_stb && t < 10) begin @(negedge clk); t++; end
        chk("pp_oldest", fpu_a, j1a);
        wait_res(base + 3, "pp_drain");

        base = n_res;
        acc = 0;
        stub_rand = 1'b1;
        rr_rand = 1'b1;
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            push_job(rnd_sp(), rnd_sp());
            acc++;
        end
        wait_res(base + acc, "rnd_drain");
        rr_rand = 1'b0;
        stub_rand = 1'b0;
        repeat (2) @(negedge clk);
        chk("rnd_queue_empty", 32'(acc_q.size()), 32'd0);

        hang_z = 1'b1;
        push_try(rnd_sp(), rnd_sp(), ok);
        push_try(rnd_sp(), rnd_sp(), ok);
        t = 0;
        while (!fpu_ack_output && t < 20) begin @(negedge clk); t++; end
        chk("ar_in_wait_z", 32'(fpu_ack_output), 32'd1);
        chk("ar_err_before", 32'(err), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_ack_output", 32'(fpu_ack_output), 32'd0);
        chk("ar_res_valid", 32'(res_valid), 32'd0);
        chk("ar_err", 32'(err), 32'd0);
        chk("ar_err_count", 32'(err_count), 32'd0);
        chk("ar_job_count", 32'(job_count), 32'd0);
        chk("ar_job_ready", 32'(job_ready), 32'd1);
        acc_q.delete();
        hang_z = 1'b0;
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        base = n_res;
        push_job(vt[3].a, vt[3].b);
        wait_res(base + 1, "ar_recover_done");
        chk("ar_recover_z", last_z, vt[3].z);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fpu_add_driver.md
Name: fpu_add_driver

Overview:
- Initiator-side controller for the single-precision FPU adder's start/strobe/ack protocol.
- Buffers operand pairs from a host in a small job FIFO, then sequences each job into the adder: start, operand A, operand B, result capture, output-valid acknowledge.
- Returns results to the host on a valid/ready port.
- A watchdog recovers from a hung adder by pulsing a dedicated adder reset.

Parameters:
DEPTH, 4, job FIFO entries (power of two, >=2)
TIMEOUT, 1024, max cycles in any FPU wait state before abort

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
job_a  in  32  operand A (IEEE-754 single)
job_b  in  32  operand B
job_valid  in  1  host offers job
job_ready  out  1  FIFO not full
job_count  out  log2(DEPTH)+1  FIFO occupancy
res_z  out  32  result
res_valid  out  1  result held
res_ready  in  1  host accepts result
fpu_start  out  1  adder start request
fpu_idle  in  1  adder idle status
fpu_a  out  32  operand A to adder
fpu_a_stb  out  1  A strobe
fpu_a_ack  in  1  adder ready for A
fpu_b  out  32  operand B to adder
fpu_b_stb  out  1  B strobe
fpu_b_ack  in  1  adder ready for B
fpu_z  in  32  adder result
fpu_z_stb  in  1  adder result strobe
fpu_ack_output  out  1  result acknowledge to adder
fpu_valid  in  1  adder output-valid phase
fpu_rst  out  1  one-cycle adder reset on timeout
err  out  1  sticky timeout flag
err_clr  in  1  clears err
err_count  out  8  saturating timeout count

Behaviour:
- Reset: asynchronous, takes effect immediately without a clock edge. FIFO emptied; state IDLE; all registered outputs 0 (fpu_a/fpu_b/res_z = 0, err_count = 0). job_ready is combinational and reads 1 while empty.
- FIFO:
  - Push on posedge when job_valid && job_ready.
  - Pop happens only from IDLE.
  - Simultaneous push and pop: both occur, count unchanged.
  - Push while full is ignored (job_ready = 0).
  - Pointers wrap modulo DEPTH.
- All handshakes are evaluated on the same posedge on both sides. A transfer completes on the edge where the strobe and the partner's signal are both high.
- States:
  - IDLE: if count > 0 && fpu_idle, pop head into op_a/op_b -> START.
  - START: fpu_start = 1 until fpu_idle samples 0 -> SEND_A. fpu_start drops on exit.
  - SEND_A: fpu_a = op_a, fpu_a_stb = 1. On fpu_a_stb && fpu_a_ack -> SEND_B, stb drops.
  - SEND_B: same pattern with op_b and fpu_b_ack -> WAIT_Z.
  - WAIT_Z: fpu_ack_output = 1. On fpu_z_stb, res_z <= fpu_z -> WAIT_VAL.
  - WAIT_VAL: fpu_ack_output stays 1. On fpu_valid, fpu_ack_output <= 0 -> PUSH.
  - PUSH: res_valid = 1, res_z stable. On res_valid && res_ready, res_valid <= 0 -> IDLE. No new job starts while res_valid = 1.
  - RECOVER: fpu_rst = 1 for exactly one cycle, the job is dropped, all fpu_* strobes, start and ack are 0 -> IDLE.
- Latency, uncontended adder: job pushed at edge N; popped at N+1; fpu_start high in cycle N+1..N+2.
- Watchdog:
  - Cycle counter clears on every state entry and counts in START, SEND_A, SEND_B, WAIT_Z and WAIT_VAL.
  - When it reaches TIMEOUT-1 without its exit condition: go to RECOVER, set err, increment err_count (saturates at 255).
  - err_clr clears err only; err_count is unaffected. If err_clr coincides with a new timeout, the timeout wins and err stays 1.
- fpu_a/fpu_b hold op_a/op_b. They are meaningful only while their strobe is high.
- The host side is never stalled by a hung adder beyond FIFO capacity.

Test Plan:
- Single job: push 0x3F800000 + 0x40000000 into a behavioural adder. Required: order is start, A, B, z capture, valid ack; res_z = 0x40400000; res_valid = 1 until res_ready.
- FIFO full: hold fpu_idle = 0 and push 5 jobs. Required: job_ready = 0 after 4 pushes, job_count = 4, 5th job not stored. Release fpu_idle: jobs complete in FIFO order.
- Back-pressure: res_ready = 0 for 20 cycles with 2 jobs queued. Required: res_valid and res_z stable, no fpu_start, job_count = 1. res_ready = 1 -> next job starts.
- Timeout: TIMEOUT = 16, stub never asserts fpu_a_ack. Required: after 16 cycles in SEND_A, fpu_rst high for exactly 1 cycle, err = 1, err_count = 1, return to IDLE, next job processed normally. err_clr -> err = 0, err_count = 1.
- Async reset mid-WAIT_Z: assert rst between clock edges. Required: fpu_ack_output, res_valid and err go 0 immediately, job_count = 0, job_ready = 1.
- Simultaneous push and pop at count = 2. Required: count stays 2, and the popped entry is the oldest.
